// File: rtl/sampler_pkg.sv
// sampler_pkg
//   Shared definitions for the constraint sample generator:
//   - state_t   : generator FSM states
//   - LFSR_W    : LFSR width (32)
//   - LFSR_MASK : Galois feedback mask for x^32+x^22+x^2+x+1
//   - lfsr_step : one Galois shift step (shift right, XOR mask if bit 0 was set)
package sampler_pkg;

   localparam int LFSR_W = 32;
   localparam logic [LFSR_W-1:0] LFSR_MASK = 32'h80200003;

   typedef enum logic [2:0] {
      IDLE,
      FILL,
      CHECK,
      DONE,
      FAIL
   } state_t;

   function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] v);
      lfsr_step = (v >> 1) ^ (v[0] ? LFSR_MASK : '0);
   endfunction

endpackage

// File: rtl/sampler_lfsr.sv
// sampler_lfsr
//   32-bit Galois LFSR that feeds candidate words to the generator.
//   A zero value is never stored: a zero seed (parameter or load) becomes 1,
//   since the all-zero state would lock the sequence.
// Ports:
//   clk      in   clock
//   rst_n    in   synchronous active-low reset (q := SEED)
//   load     in   load load_val (takes priority over advance)
//   load_val in   32  value to load
//   advance  in   step the LFSR once
//   q        out  32  current LFSR value
module sampler_lfsr
   import sampler_pkg::*;
#(
   parameter logic [LFSR_W-1:0] SEED = 32'h1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic [LFSR_W-1:0] load_val,
   input  logic              advance,
   output logic [LFSR_W-1:0] q
);

   localparam logic [LFSR_W-1:0] SEED_SAFE = (SEED == '0) ? LFSR_W'(1) : SEED;

   logic [LFSR_W-1:0] q_reg;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         q_reg <= SEED_SAFE;
      end else if (load) begin
         q_reg <= (load_val == '0) ? LFSR_W'(1) : load_val;
      end else if (advance) begin
         q_reg <= lfsr_step(q_reg);
      end
   end

   assign q = q_reg;

endmodule

// File: rtl/constraint_sample_gen.sv
// constraint_sample_gen
//   Builds random candidate assignments from an LFSR, presents them to an
//   external combinational checker, retries on rejection until accepted or
//   the try budget runs out, and hands accepted samples to a valid/ready sink.
//   Optional statistics counters are enabled with the macro SAMPLER_STATS_EN.
// Ports:
//   clk, rst_n        clock and synchronous active-low reset
//   start             begin a run (IDLE or FAIL only)
//   seed_load, seed   reload the LFSR (IDLE only; seed 0 becomes 1)
//   cand_o            candidate bus, var k = cand_o[k*VAR_W +: VAR_W]
//   chk_ok_i          checker verdict for cand_o, sampled once per CHECK
//   sample_valid/ready/data  accepted-sample stream
//   busy, fail, tries status
//   stat_accepts, stat_rejects  (SAMPLER_STATS_EN only) saturating counters
module constraint_sample_gen
   import sampler_pkg::*;
#(
   parameter int                NUM_VARS  = 20,
   parameter int                VAR_W     = 32,
   parameter int                MAX_TRIES = 1024,
   parameter logic [LFSR_W-1:0] SEED      = 32'h1,
   localparam int               CAND_W    = NUM_VARS * VAR_W,
   localparam int               TRY_W     = $clog2(MAX_TRIES + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              seed_load,
   input  logic [31:0]       seed,
   output logic [CAND_W-1:0] cand_o,
   input  logic              chk_ok_i,
   output logic              sample_valid,
   input  logic              sample_ready,
   output logic [CAND_W-1:0] sample_data,
   output logic              busy,
   output logic              fail,
   output logic [TRY_W-1:0]  tries
`ifdef SAMPLER_STATS_EN
   ,
   output logic [31:0]       stat_accepts,
   output logic [31:0]       stat_rejects
`endif
);

   localparam int WC_W = (NUM_VARS > 1) ? $clog2(NUM_VARS) : 1;

   state_t            state_reg, state_next;
   logic [CAND_W-1:0] cand_reg;
   logic [TRY_W-1:0]  tries_reg;
   logic [WC_W-1:0]   word_cnt_reg;
   logic [LFSR_W-1:0] lfsr_q;
   logic [VAR_W-1:0]  slot_word;
   logic              last_word;
   logic              budget_spent;

   sampler_lfsr #(.SEED(SEED)) u_lfsr (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     ((state_reg == IDLE) && seed_load),
      .load_val (seed),
      .advance  (state_reg == FILL),
      .q        (lfsr_q)
   );

   // Size cast zero-extends or truncates the LFSR word to one slot.
   assign slot_word    = VAR_W'(lfsr_q);
   assign last_word    = (word_cnt_reg == WC_W'(NUM_VARS - 1));
   assign budget_spent = (tries_reg == TRY_W'(MAX_TRIES - 1));

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (start) state_next = FILL;
         FILL:    if (last_word) state_next = CHECK;
         CHECK: begin
            if (chk_ok_i)          state_next = DONE;
            else if (budget_spent) state_next = FAIL;
            else                   state_next = FILL;
         end
         DONE:    if (sample_ready) state_next = IDLE;
         FAIL:    if (start) state_next = FILL;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg    <= IDLE;
         cand_reg     <= '0;
         tries_reg    <= '0;
         word_cnt_reg <= '0;
      end else begin
         state_reg <= state_next;
         case (state_reg)
            IDLE, FAIL: begin
               if (start) begin
                  tries_reg    <= '0;
                  word_cnt_reg <= '0;
               end
            end
            FILL: begin
               // New word enters the top slot; after NUM_VARS shifts the
               // first word has reached var 0.
               cand_reg     <= (cand_reg >> VAR_W) |
                               (CAND_W'(slot_word) << (CAND_W - VAR_W));
               word_cnt_reg <= last_word ? '0 : word_cnt_reg + 1'b1;
            end
            CHECK: begin
               if (!chk_ok_i) tries_reg <= tries_reg + 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign cand_o       = cand_reg;
   assign sample_data  = cand_reg;
   assign sample_valid = (state_reg == DONE);
   assign busy         = (state_reg == FILL) || (state_reg == CHECK) || (state_reg == DONE);
   assign fail         = (state_reg == FAIL);
   assign tries        = tries_reg;

`ifdef SAMPLER_STATS_EN
   logic [31:0] stat_accepts_reg, stat_rejects_reg;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stat_accepts_reg <= '0;
         stat_rejects_reg <= '0;
      end else if (state_reg == CHECK) begin
         if (chk_ok_i) begin
            if (stat_accepts_reg != 32'hFFFF_FFFF) stat_accepts_reg <= stat_accepts_reg + 1'b1;
         end else begin
            if (stat_rejects_reg != 32'hFFFF_FFFF) stat_rejects_reg <= stat_rejects_reg + 1'b1;
         end
      end
   end

   assign stat_accepts = stat_accepts_reg;
   assign stat_rejects = stat_rejects_reg;
`endif

endmodule

// File: tb/tb_constraint_sample_gen.sv
// tb_constraint_sample_gen
//   Directed bench for constraint_sample_gen. A reference LFSR predicts each
//   accepted candidate; predictions are queued when a run starts and popped
//   when the sample appears. Build with SAMPLER_STATS_EN to cover counters.
module tb_constraint_sample_gen;

   localparam int          NV     = 20;
   localparam int          VW     = 32;
   localparam int          MT     = 4;
   localparam logic [31:0] SD     = 32'h1;
   localparam int          CW     = NV * VW;
   localparam int          TW     = $clog2(MT + 1);
   localparam int          PERIOD = NV + 1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          seed_load = 1'b0;
   logic [31:0]   seed = '0;
   logic          chk_ok_i = 1'b0;
   logic          sample_ready = 1'b0;
   logic [CW-1:0] cand_o, sample_data;
   logic          sample_valid, busy, fail;
   logic [TW-1:0] tries;
`ifdef SAMPLER_STATS_EN
   logic [31:0]   stat_accepts, stat_rejects;
`endif

   int            checks = 0;
   int            failures = 0;
   logic [31:0]   m_lfsr = SD;
   logic [CW-1:0] exp_q[$];
   int            tries_q[$];
   int            end_j;

   always #5 clk = ~clk;

   constraint_sample_gen #(
      .NUM_VARS(NV), .VAR_W(VW), .MAX_TRIES(MT), .SEED(SD)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .seed_load    (seed_load),
      .seed         (seed),
      .cand_o       (cand_o),
      .chk_ok_i     (chk_ok_i),
      .sample_valid (sample_valid),
      .sample_ready (sample_ready),
      .sample_data  (sample_data),
      .busy         (busy),
      .fail         (fail),
      .tries        (tries)
`ifdef SAMPLER_STATS_EN
      ,
      .stat_accepts (stat_accepts),
      .stat_rejects (stat_rejects)
`endif
   );

   function automatic logic [31:0] ref_step(input logic [31:0] v);
      logic [31:0] r;
      r = v >> 1;
      if (v[0]) r = r ^ 32'h80200003;
      return r;
   endfunction

   task automatic check(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One run: accept_at = attempt number that is accepted (0 = never, run
   // must exhaust the budget); tamper_j = cycle with a seed_load that must
   // be ignored; ld/ld_val = seed_load together with start.
   task automatic do_run(input int accept_at, input int tamper_j,
                         input logic ld, input logic [31:0] ld_val, output int ej);
      logic [CW-1:0] c;
      int            n_att;
      logic          exp_fail;
      exp_fail = (accept_at == 0);
      if (ld) m_lfsr = (ld_val == 32'h0) ? 32'h1 : ld_val;
      n_att = exp_fail ? MT : accept_at;
      c = '0;
      for (int a = 0; a < n_att; a++) begin
         for (int k = 0; k < NV; k++) begin
            c[k*VW +: VW] = m_lfsr;
            m_lfsr = ref_step(m_lfsr);
         end
      end
      if (!exp_fail) begin
         exp_q.push_back(c);
         tries_q.push_back(accept_at - 1);
      end
      @(negedge clk);
      start = 1'b1; seed_load = ld; seed = ld_val; chk_ok_i = 1'b0;
      @(negedge clk);
      start = 1'b0; seed_load = 1'b0;
      check("start_busy", busy, 1);
      check("start_fail_clr", fail, 0);
      check("start_tries_clr", tries, 0);
      ej = -1;
      for (int j = 1; j <= (MT + 1) * PERIOD + 4; j++) begin
         if (sample_valid || fail) begin
            ej = j;
            break;
         end
         chk_ok_i  = !exp_fail && (j == accept_at * PERIOD);
         seed_load = (j == tamper_j);
         seed      = 32'hDEADBEEF;
         @(negedge clk);
      end
      chk_ok_i = 1'b0; seed_load = 1'b0;
      check("run_end_cycle", ej, exp_fail ? MT * PERIOD + 1 : accept_at * PERIOD + 1);
      $display("run accept_at=%0d end_cycle=%0d valid=%0b fail=%0b tries=%0d",
               accept_at, ej, sample_valid, fail, tries);
   endtask

   task automatic finish_sample(input int hold);
      logic [CW-1:0] e, snap;
      int            et;
      e  = exp_q.pop_front();
      et = tries_q.pop_front();
      check("sample_data", sample_data, e);
      check("cand_eq_sample", cand_o, e);
      check("tries_at_accept", tries, et);
      snap = sample_data;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check("bp_valid", sample_valid, 1);
         check("bp_data", sample_data, snap);
      end
      sample_ready = 1'b1;
      @(negedge clk);
      sample_ready = 1'b0;
      check("post_valid", sample_valid, 0);
      check("post_busy", busy, 0);
      $display("transfer var0=%0h hold=%0d", snap[VW-1:0], hold);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_cand", cand_o, 0);
      check("rst_valid", sample_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_fail", fail, 0);
      check("rst_tries", tries, 0);
      rst_n = 1'b1;

      // Always-accept with backpressure
      do_run(1, 0, 1'b0, 32'h0, end_j);
      check("aa_var0", sample_data[0 +: VW], 32'h1);
      check("aa_var1", sample_data[VW +: VW], 32'h80200003);
      finish_sample(5);

      // Accept on the 4th attempt
      do_run(4, 0, 1'b0, 32'h0, end_j);
      finish_sample(0);

      // Budget exhaustion, fail holds, then a new run clears it
      do_run(0, 0, 1'b0, 32'h0, end_j);
      check("ex_fail", fail, 1);
      check("ex_tries", tries, MT);
      check("ex_valid", sample_valid, 0);
      check("ex_busy", busy, 0);
      repeat (3) @(negedge clk);
      check("ex_fail_hold", fail, 1);
      do_run(2, 0, 1'b0, 32'h0, end_j);
      finish_sample(0);

      // Zero seed becomes 1; seed_load during FILL is ignored
      @(negedge clk);
      seed_load = 1'b1; seed = 32'h0;
      @(negedge clk);
      seed_load = 1'b0;
      m_lfsr = 32'h1;
      do_run(1, 3, 1'b0, 32'h0, end_j);
      check("seed0_var0", sample_data[0 +: VW], 32'h1);
      finish_sample(0);

      // seed_load together with start: run uses the new seed
      do_run(1, 0, 1'b1, 32'h12345678, end_j);
      check("seedst_var0", sample_data[0 +: VW], 32'h12345678);
      finish_sample(0);

`ifdef SAMPLER_STATS_EN
      check("stat_acc", stat_accepts, 5);
      check("stat_rej", stat_rejects, 8);
`endif

      // Reset in the middle of FILL
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (6) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check("mrst_cand", cand_o, 0);
      check("mrst_valid", sample_valid, 0);
      check("mrst_busy", busy, 0);
      check("mrst_fail", fail, 0);
      check("mrst_tries", tries, 0);
`ifdef SAMPLER_STATS_EN
      check("mrst_stat_acc", stat_accepts, 0);
      check("mrst_stat_rej", stat_rejects, 0);
`endif
      rst_n = 1'b1;
      m_lfsr = SD;
      do_run(1, 0, 1'b0, 32'h0, end_j);
      check("mrst_var0", sample_data[0 +: VW], SD);
      finish_sample(0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
